fix2flt_batch_seq: RTL and testbench

//  Sequencer for the fix(8.8)->float16 conversion core. It converts a batch of operands stored in data memory.
//  Per operand: read 2 source bytes, pulse the core's start, wait for its done, write 2 result bytes, advance pointers.

---
 rtl/fix2flt_pkg.sv | 28 ++
 rtl/cv_watchdog.sv | 33 +++
 rtl/fix2flt_batch_seq.sv | 171 +++++++++++++++++
 tb/tb_fix2flt_batch_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix2flt_pkg.sv
// Shared types and defaults for the fix(8.8)->float16 batch sequencer.
package fix2flt_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_LO,
      ST_RD_HI,
      ST_START,
      ST_WAIT,
      ST_WR_LO,
      ST_WR_HI,
      ST_NEXT,
      ST_FIN
   } state_t;

   localparam logic [7:0]  SRC_BASE_DEF   = 8'd0;
   localparam logic [7:0]  DST_BASE_DEF   = 8'd64;
   localparam logic [15:0] TIMEOUT_DEF    = 16'd4095;
   localparam logic [7:0]  BYTES_PER_ITEM = 8'd2;

   // Byte address of the lo (hi=0) or hi (hi=1) byte of item idx; wraps modulo 256.
   function automatic logic [7:0] item_addr(input logic [7:0] base,
                                            input logic [6:0] idx,
                                            input logic       hi);
      return base + ({1'b0, idx} * BYTES_PER_ITEM) + {7'b0, hi};
   endfunction

endpackage

// File: rtl/cv_watchdog.sv
// Converter watchdog: down-counter loaded with LIMIT on clear, expires at terminal count 0.
module cv_watchdog #(
   parameter logic [15:0] LIMIT = 16'd4095
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   logic [15:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == 16'd0);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = LIMIT;
      end else if (enable_i && !expired_o) begin
         cnt_d = cnt_q - 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fix2flt_batch_seq.sv
// Batch sequencer: streams operands from dat_mem through the fix->float16 converter
// and writes each result back, with a watchdog on the converter handshake.
//
// state   | meaning
// IDLE    | waiting for go
// RD_LO   | read operand lo byte
// RD_HI   | read operand hi byte, load cv_operand
// START   | one-cycle converter start, watchdog reload
// WAIT    | wait for armed cv_done or watchdog expiry
// WR_LO   | write result lo byte
// WR_HI   | write result hi byte
// NEXT    | advance index, decide loop or finish
// FIN     | one-cycle done pulse
module fix2flt_batch_seq
   import fix2flt_pkg::*;
#(
   parameter logic [7:0]  SRC_BASE = SRC_BASE_DEF,
   parameter logic [7:0]  DST_BASE = DST_BASE_DEF,
   parameter logic [15:0] TIMEOUT  = TIMEOUT_DEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        go_i,
   input  logic [6:0]  count_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [6:0]  items_done_o,
   output logic [7:0]  mem_addr_o,
   output logic        mem_wr_en_o,
   output logic [7:0]  mem_wdata_o,
   input  logic [7:0]  mem_rdata_i,
   output logic        cv_start_o,
   output logic [15:0] cv_operand_o,
   input  logic        cv_done_i,
   input  logic [15:0] cv_result_i
);

   state_t      state_q, state_d;
   logic [6:0]  count_q, count_d;
   logic [6:0]  idx_q, idx_d;
   logic [6:0]  items_q, items_d;
   logic [7:0]  lo_q, lo_d;
   logic [15:0] operand_q, operand_d;
   logic [15:0] result_q, result_d;
   logic        err_q, err_d;
   logic        armed_q, armed_d;
   logic        wd_clear, wd_enable, wd_expired;

   cv_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (wd_clear),
      .enable_i  (wd_enable),
      .expired_o (wd_expired)
   );

   assign err_o        = err_q;
   assign items_done_o = items_q;
   assign cv_operand_o = operand_q;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      idx_d       = idx_q;
      items_d     = items_q;
      lo_d        = lo_q;
      operand_d   = operand_q;
      result_d    = result_q;
      err_d       = err_q;
      armed_d     = armed_q;
      wd_clear    = 1'b0;
      wd_enable   = 1'b0;
      mem_addr_o  = 8'd0;
      mem_wr_en_o = 1'b0;
      mem_wdata_o = 8'd0;
      cv_start_o  = 1'b0;
      done_o      = 1'b0;
      busy_o      = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (go_i) begin
               count_d = count_i;
               idx_d   = 7'd0;
               items_d = 7'd0;
               err_d   = 1'b0;
               state_d = (count_i == 7'd0) ? ST_FIN : ST_RD_LO;
            end
         end
         ST_RD_LO: begin
            mem_addr_o = item_addr(SRC_BASE, idx_q, 1'b0);
            lo_d       = mem_rdata_i;
            state_d    = ST_RD_HI;
         end
         ST_RD_HI: begin
            // Operand changes only on entry to START so it stays stable between starts.
            mem_addr_o = item_addr(SRC_BASE, idx_q, 1'b1);
            operand_d  = {mem_rdata_i, lo_q};
            state_d    = ST_START;
         end
         ST_START: begin
            cv_start_o = 1'b1;
            armed_d    = 1'b0;
            wd_clear   = 1'b1;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            // A done still high from the previous conversion is ignored until it has dropped.
            wd_enable = 1'b1;
            armed_d   = armed_q | ~cv_done_i;
            if (cv_done_i && armed_q) begin
               result_d = cv_result_i;
               state_d  = ST_WR_LO;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end
         end
         ST_WR_LO: begin
            mem_addr_o  = item_addr(DST_BASE, idx_q, 1'b0);
            mem_wdata_o = result_q[7:0];
            mem_wr_en_o = 1'b1;
            state_d     = ST_WR_HI;
         end
         ST_WR_HI: begin
            mem_addr_o  = item_addr(DST_BASE, idx_q, 1'b1);
            mem_wdata_o = result_q[15:8];
            mem_wr_en_o = 1'b1;
            state_d     = ST_NEXT;
         end
         ST_NEXT: begin
            items_d = items_q + 7'd1;
            idx_d   = idx_q + 7'd1;
            state_d = (idx_d == count_q) ? ST_FIN : ST_RD_LO;
         end
         ST_FIN: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         idx_q     <= '0;
         items_q   <= '0;
         lo_q      <= '0;
         operand_q <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         items_q   <= items_d;
         lo_q      <= lo_d;
         operand_q <= operand_d;
         result_q  <= result_d;
         err_q     <= err_d;
         armed_q   <= armed_d;
      end
   end

endmodule

// File: tb/tb_fix2flt_batch_seq.sv
// Scoreboard bench for fix2flt_batch_seq: directed batches against a memory and converter model.
module tb_fix2flt_batch_seq;

   localparam logic [15:0] TB_TIMEOUT = 16'd24;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic [6:0]  count = 7'd0;
   logic        busy, done, err, mem_wr_en, cv_start;
   logic [6:0]  items_done;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic [15:0] cv_operand, cv_result;
   logic        cv_done_m = 1'b1;

   fix2flt_batch_seq #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .go_i         (go),
      .count_i      (count),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .items_done_o (items_done),
      .mem_addr_o   (mem_addr),
      .mem_wr_en_o  (mem_wr_en),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata),
      .cv_start_o   (cv_start),
      .cv_operand_o (cv_operand),
      .cv_done_i    (cv_done_m),
      .cv_result_i  (cv_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Data memory model
   logic [7:0] mem [0:255];
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_wr_en) mem[mem_addr] = mem_wdata;

   // Converter model: optional stale-done phase, then lat_n cycles low, then done
   int   lat_n = 1, stale_n = 0, ph = 0, cnt = 0;
   bit   hang = 1'b0, swap_mode = 1'b0;
   logic [15:0] fixed_res = 16'h0000;
   assign cv_result = swap_mode ? {cv_operand[7:0], cv_operand[15:8]} : fixed_res;

   always @(posedge clk) begin
      if (cv_start) begin
         if (stale_n != 0) begin ph <= 1; cnt <= stale_n - 1; cv_done_m <= 1'b1; end
         else begin ph <= 2; cnt <= lat_n - 1; cv_done_m <= 1'b0; end
      end else if (ph == 1) begin
         if (cnt == 0) begin ph <= 2; cnt <= lat_n - 1; cv_done_m <= 1'b0; end
         else cnt <= cnt - 1;
      end else if (ph == 2 && !hang) begin
         if (cnt == 0) begin ph <= 0; cv_done_m <= 1'b1; end
         else cnt <= cnt - 1;
      end
   end

   // Scoreboard
   typedef struct { logic [7:0] addr; logic [7:0] data; int lat; } wr_t;
   typedef struct { logic [15:0] op; int gap; } op_t;
   typedef struct { logic [6:0] items; logic err; int lat; } dn_t;
   wr_t wr_q[$];
   op_t op_q[$];
   dn_t dn_q[$];
   wr_t w;
   op_t o;
   dn_t d;
   int n_cmp = 0, n_bad = 0;
   int go_cyc = 0, start_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected DUT event with empty scoreboard (cycle %0d)", name, cyc);
   endtask

   always @(negedge clk) if (rst_n) begin
      if (cv_start) begin
         if (op_q.size() == 0) unexpected("cv_start");
         else begin
            o = op_q.pop_front();
            chk("cv_operand", 32'(cv_operand), 32'(o.op));
            if (o.gap > 0) chk("start_gap", cyc - start_cyc, o.gap);
         end
         start_cyc = cyc;
      end
      if (mem_wr_en) begin
         if (wr_q.size() == 0) unexpected("mem_wr_en");
         else begin
            w = wr_q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(w.addr));
            chk("wr_data", 32'(mem_wdata), 32'(w.data));
            if (w.lat > 0) chk("wr_latency", cyc - start_cyc, w.lat);
         end
      end
      if (done) begin
         if (dn_q.size() == 0) unexpected("done");
         else begin
            d = dn_q.pop_front();
            chk("items_done", 32'(items_done), 32'(d.items));
            chk("err", 32'(err), 32'(d.err));
            chk("busy_at_done", 32'(busy), 32'd1);
            chk("done_latency", cyc - go_cyc, d.lat);
         end
      end
   end

   task automatic start_batch(input logic [6:0] n);
      @(negedge clk);
      go = 1'b1;
      count = n;
      go_cyc = cyc;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int k = 0;
      while (!done && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
      end
      @(negedge clk);
      chk("busy_after_fin", 32'(busy), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_items"}, 32'(items_done), 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_wr_en"}, 32'(mem_wr_en), 0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 0);
      chk({tag, "_start"}, 32'(cv_start), 0);
      chk({tag, "_operand"}, 32'(cv_operand), 0);
   endtask

   task automatic fill_dst();
      for (int i = 64; i < 72; i++) mem[i] = 8'hEE;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single item: 0x0180 -> 0x3E00, converter busy 4 cycles (item = 11 cycles)
      mem[0] = 8'h80; mem[1] = 8'h01;
      fixed_res = 16'h3E00; swap_mode = 1'b0; lat_n = 4; stale_n = 0;
      op_q.push_back('{16'h0180, 0});
      wr_q.push_back('{8'd64, 8'h00, 6});
      wr_q.push_back('{8'd65, 8'h3E, 0});
      dn_q.push_back('{7'd1, 1'b0, 12});
      start_batch(7'd1);
      wait_done(100);
      chk("mem64", 32'(mem[64]), 32'h00);
      chk("mem65", 32'(mem[65]), 32'h3E);

      // Three items, converter busy 20 cycles -> 27 cycles per item, results = byte-swapped operand
      fill_dst();
      mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'hCD; mem[3] = 8'hAB;
      mem[4] = 8'hFF; mem[5] = 8'h00;
      swap_mode = 1'b1; lat_n = 20;
      op_q.push_back('{16'h1234, 0});
      op_q.push_back('{16'hABCD, 27});
      op_q.push_back('{16'h00FF, 27});
      wr_q.push_back('{8'd64, 8'h12, 22}); wr_q.push_back('{8'd65, 8'h34, 0});
      wr_q.push_back('{8'd66, 8'hAB, 22}); wr_q.push_back('{8'd67, 8'hCD, 0});
      wr_q.push_back('{8'd68, 8'h00, 22}); wr_q.push_back('{8'd69, 8'hFF, 0});
      dn_q.push_back('{7'd3, 1'b0, 82});
      start_batch(7'd3);
      wait_done(200);
      chk("mem69", 32'(mem[69]), 32'hFF);

      // Empty batch: straight to FIN, no memory or converter activity
      dn_q.push_back('{7'd0, 1'b0, 1});
      start_batch(7'd0);
      wait_done(10);

      // Converter never answers: watchdog aborts after TB_TIMEOUT+1 WAIT cycles
      fill_dst();
      hang = 1'b1; lat_n = 2;
      op_q.push_back('{16'h1234, 0});
      dn_q.push_back('{7'd0, 1'b1, int'(TB_TIMEOUT) + 5});
      start_batch(7'd1);
      wait_done(200);
      chk("err_sticky", 32'(err), 32'd1);
      chk("mem64_untouched", 32'(mem[64]), 32'hEE);
      chk("mem65_untouched", 32'(mem[65]), 32'hEE);
      hang = 1'b0;

      // Stale done held high through START: 3 ignored cycles, then 5 low, then done
      stale_n = 3; lat_n = 5;
      op_q.push_back('{16'h1234, 0});
      wr_q.push_back('{8'd64, 8'h12, 10});
      wr_q.push_back('{8'd65, 8'h34, 0});
      dn_q.push_back('{7'd1, 1'b0, 16});
      start_batch(7'd1);
      wait_done(100);

      // Reset during WAIT of the third item of a 4-item batch
      fill_dst();
      stale_n = 0; lat_n = 6;
      mem[6] = 8'h78; mem[7] = 8'h56;
      op_q.push_back('{16'h1234, 0});
      op_q.push_back('{16'hABCD, 13});
      op_q.push_back('{16'h00FF, 13});
      wr_q.push_back('{8'd64, 8'h12, 8}); wr_q.push_back('{8'd65, 8'h34, 0});
      wr_q.push_back('{8'd66, 8'hAB, 8}); wr_q.push_back('{8'd67, 8'hCD, 0});
      start_batch(7'd4);
      begin
         int k = 0;
         while (op_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
         end
         chk("starts_before_reset", 32'(op_q.size()), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      chk("mem64_kept", 32'(mem[64]), 32'h12);
      chk("mem67_kept", 32'(mem[67]), 32'hCD);
      chk("mem68_untouched", 32'(mem[68]), 32'hEE);
      chk("mem69_untouched", 32'(mem[69]), 32'hEE);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      chk("wr_q_left", 32'(wr_q.size()), 0);
      chk("op_q_left", 32'(op_q.size()), 0);
      chk("dn_q_left", 32'(dn_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
